// File: rtl/exec_pkg.sv
// Shared types for the execute unit: ARM data-processing opcodes, shift kinds,
// NZCV bit positions and opcode classification helpers.
package exec_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } dp_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
  } shift_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_logical(input dp_op_e op);
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: is_logical = 1'b1;
      default:                        is_logical = 1'b0;
    endcase
  endfunction

  function automatic logic is_compare(input dp_op_e op);
    case (op)
      OP_TST, OP_TEQ, OP_CMP, OP_CMN: is_compare = 1'b1;
      default:                        is_compare = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_shift_unit.sv
// Combinational ARM operand-2 barrel shifter with carry out, covering both
// immediate (imm5 encodings incl. RRX) and register-specified amounts.
module arm_shift_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       shift_type_i,
  input  logic [7:0]       amt_i,
  input  logic             by_reg_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o
);

  localparam int           LW    = $clog2(WIDTH);
  localparam logic [8:0]   W_AMT = 9'(WIDTH);

  shift_e               sh_s;
  logic [8:0]           n_s;
  logic [WIDTH:0]       lsl_s;
  logic [WIDTH:0]       lsr_s;
  logic [WIDTH:0]       asr_s;
  logic [LW-1:0]        rot_s;
  logic [2*WIDTH-1:0]   ror_s;

  // One extra bit beside the operand catches the last bit shifted out, so every
  // amount (including >= WIDTH) falls out of a plain shift.
  always_comb begin
    sh_s  = shift_e'(shift_type_i);
    n_s   = {1'b0, amt_i};
    if (!by_reg_i && (amt_i == 8'd0) && ((sh_s == SH_LSR) || (sh_s == SH_ASR))) begin
      n_s = W_AMT;
    end else begin
      n_s = {1'b0, amt_i};
    end
    lsl_s = {1'b0, b_i} << n_s;
    lsr_s = {b_i, 1'b0} >> n_s;
    asr_s = $signed({b_i, 1'b0}) >>> n_s;
    rot_s = amt_i[LW-1:0];
    ror_s = {b_i, b_i} >> rot_s;

    res_o  = b_i;
    cout_o = cin_i;
    if (by_reg_i && (amt_i == 8'd0)) begin
      res_o  = b_i;
      cout_o = cin_i;
    end else if (!by_reg_i && (amt_i == 8'd0) && (sh_s == SH_LSL)) begin
      res_o  = b_i;
      cout_o = cin_i;
    end else if (!by_reg_i && (amt_i == 8'd0) && (sh_s == SH_ROR)) begin
      res_o  = {cin_i, b_i[WIDTH-1:1]};
      cout_o = b_i[0];
    end else begin
      case (sh_s)
        SH_LSL:  begin res_o = lsl_s[WIDTH-1:0]; cout_o = lsl_s[WIDTH]; end
        SH_LSR:  begin res_o = lsr_s[WIDTH:1];   cout_o = lsr_s[0];     end
        SH_ASR:  begin res_o = asr_s[WIDTH:1];   cout_o = asr_s[0];     end
        SH_ROR:  begin res_o = ror_s[WIDTH-1:0]; cout_o = ror_s[WIDTH-1]; end
        default: begin res_o = b_i;              cout_o = cin_i;        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_exec_unit.sv
// Two-stage ARM data-processing execute unit: S1 holds the raw op and feeds the
// shifter, S2 holds the shifted operand and feeds the ALU and NZCV register.
module pipe_exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       shift_type,
  input  logic [7:0]       shift_amt,
  input  logic             shift_by_reg,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_wr,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags
);

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_op_q;
  logic             s1_sf_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [1:0]       s1_sh_type_q;
  logic [7:0]       s1_sh_amt_q;
  logic             s1_by_reg_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_valid_d;
  logic [3:0]       s2_op_q;
  logic             s2_sf_q;
  logic [WIDTH-1:0] s2_a_q, s2_sh_q;
  logic             s2_shc_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic [3:0]       flags_q, flags_d;

  logic             adv1_s, adv2_s, retire_s, load1_s, load2_s;
  logic             fwd_c_s;
  logic [WIDTH-1:0] sh_res_s;
  logic             sh_c_s;
  dp_op_e           op2_s;
  logic [WIDTH-1:0] x_s, y_s, logic_res_s, alu_res_s;
  logic             alu_cin_s;
  logic [WIDTH:0]   sum_s;
  logic [3:0]       nzcv_s;

  // A flag-setting op in S2 retires before S1's op, so S1 must see its carry.
  assign fwd_c_s = (s2_valid_q && s2_sf_q) ? nzcv_s[FLAG_C] : flags_q[FLAG_C];

  arm_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .b_i          (s1_b_q),
    .shift_type_i (s1_sh_type_q),
    .amt_i        (s1_sh_amt_q),
    .by_reg_i     (s1_by_reg_q),
    .cin_i        (fwd_c_s),
    .res_o        (sh_res_s),
    .cout_o       (sh_c_s)
  );

  // ALU: operand selection, adder and NZCV generation for the op in S2.
  always_comb begin
    op2_s       = dp_op_e'(s2_op_q);
    x_s         = '0;
    y_s         = '0;
    alu_cin_s   = 1'b0;
    logic_res_s = '0;
    case (op2_s)
      OP_AND, OP_TST: logic_res_s = s2_a_q & s2_sh_q;
      OP_EOR, OP_TEQ: logic_res_s = s2_a_q ^ s2_sh_q;
      OP_ORR:         logic_res_s = s2_a_q | s2_sh_q;
      OP_BIC:         logic_res_s = s2_a_q & ~s2_sh_q;
      OP_MOV:         logic_res_s = s2_sh_q;
      OP_MVN:         logic_res_s = ~s2_sh_q;
      OP_SUB, OP_CMP: begin x_s = s2_a_q;  y_s = ~s2_sh_q; alu_cin_s = 1'b1; end
      OP_RSB:         begin x_s = s2_sh_q; y_s = ~s2_a_q;  alu_cin_s = 1'b1; end
      OP_ADD, OP_CMN: begin x_s = s2_a_q;  y_s = s2_sh_q;  alu_cin_s = 1'b0; end
      OP_ADC:         begin x_s = s2_a_q;  y_s = s2_sh_q;  alu_cin_s = flags_q[FLAG_C]; end
      OP_SBC:         begin x_s = s2_a_q;  y_s = ~s2_sh_q; alu_cin_s = flags_q[FLAG_C]; end
      OP_RSC:         begin x_s = s2_sh_q; y_s = ~s2_a_q;  alu_cin_s = flags_q[FLAG_C]; end
      default:        logic_res_s = s2_sh_q;
    endcase
    sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, alu_cin_s};
    if (is_logical(op2_s)) begin
      alu_res_s = logic_res_s;
      nzcv_s    = {alu_res_s[WIDTH-1], (alu_res_s == '0), s2_shc_q, flags_q[FLAG_V]};
    end else begin
      alu_res_s = sum_s[WIDTH-1:0];
      nzcv_s    = {alu_res_s[WIDTH-1], (alu_res_s == '0), sum_s[WIDTH],
                   (x_s[WIDTH-1] == y_s[WIDTH-1]) && (alu_res_s[WIDTH-1] != x_s[WIDTH-1])};
    end
  end

  // Handshake and next-state for the valid bits and the flag register.
  always_comb begin
    adv2_s     = !s2_valid_q || out_ready;
    adv1_s     = !s1_valid_q || adv2_s;
    retire_s   = s2_valid_q && out_ready;
    load1_s    = in_valid && adv1_s && !flush;
    load2_s    = s1_valid_q && adv2_s && !flush;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    flags_d    = flags_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (adv2_s) s2_valid_d = s1_valid_q;
      else        s2_valid_d = s2_valid_q;
      if (adv1_s) s1_valid_d = in_valid;
      else        s1_valid_d = s1_valid_q;
      if (retire_s && s2_sf_q) flags_d = nzcv_s;
      else                     flags_d = flags_q;
    end
  end

  // Pipeline registers; data only moves on a load so a stalled S2 stays stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      flags_q      <= 4'b0000;
      s1_op_q      <= 4'h0;
      s1_sf_q      <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_sh_type_q <= 2'd0;
      s1_sh_amt_q  <= 8'd0;
      s1_by_reg_q  <= 1'b0;
      s1_tag_q     <= '0;
      s2_op_q      <= 4'h0;
      s2_sf_q      <= 1'b0;
      s2_a_q       <= '0;
      s2_sh_q      <= '0;
      s2_shc_q     <= 1'b0;
      s2_tag_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      flags_q    <= flags_d;
      if (load1_s) begin
        s1_op_q      <= op;
        s1_sf_q      <= set_flags;
        s1_a_q       <= src_a;
        s1_b_q       <= src_b;
        s1_sh_type_q <= shift_type;
        s1_sh_amt_q  <= shift_amt;
        s1_by_reg_q  <= shift_by_reg;
        s1_tag_q     <= tag;
      end
      if (load2_s) begin
        s2_op_q  <= s1_op_q;
        s2_sf_q  <= s1_sf_q;
        s2_a_q   <= s1_a_q;
        s2_sh_q  <= sh_res_s;
        s2_shc_q <= sh_c_s;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign in_ready  = adv1_s && !flush;
  assign out_valid = s2_valid_q;
  assign result    = alu_res_s;
  assign result_wr = !is_compare(dp_op_e'(s2_op_q));
  assign out_tag   = s2_tag_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_pipe_exec_unit.sv
// Directed bench for pipe_exec_unit with hand-computed expected results and flags.
module tb_pipe_exec_unit;

  localparam logic [3:0] OP_SUB = 4'h2, OP_ADD = 4'h4, OP_CMP = 4'hA,
                         OP_ORR = 4'hC, OP_MOV = 4'hD;
  localparam logic [1:0] LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, ROR = 2'd3;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, set_flags, shift_by_reg;
  logic [3:0]  op, flags;
  logic [31:0] src_a, src_b, result;
  logic [1:0]  shift_type;
  logic [7:0]  shift_amt;
  logic [4:0]  tag, out_tag;
  logic        out_valid, out_ready, result_wr;

  int n_vec = 0;
  int n_err = 0;

  pipe_exec_unit #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .set_flags(set_flags), .src_a(src_a), .src_b(src_b),
    .shift_type(shift_type), .shift_amt(shift_amt), .shift_by_reg(shift_by_reg),
    .tag(tag), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_wr(result_wr), .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic sf, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] st, input logic [7:0] amt, input logic br, input logic [4:0] tg);
    in_valid = 1'b1; op = o; set_flags = sf; src_a = a; src_b = b;
    shift_type = st; shift_amt = amt; shift_by_reg = br; tag = tg;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] st, input logic [7:0] amt, input logic br,
                         input logic [31:0] exp_res, input logic exp_wr, input logic [3:0] exp_fl);
    drive(o, 1'b1, a, b, st, amt, br, 5'd9);
    tick();
    idle();
    tick();
    chk_eq({name, "_vld"}, 64'(out_valid), 64'd1);
    chk_eq({name, "_res"}, 64'(result), 64'(exp_res));
    chk_eq({name, "_wr"}, 64'(result_wr), 64'(exp_wr));
    tick();
    chk_eq({name, "_flags"}, 64'(flags), 64'(exp_fl));
  endtask

  logic [3:0]  q_op[4];
  logic        q_sf[4];
  logic [31:0] q_a[4], q_b[4], q_res[4];
  logic [3:0]  q_fl[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(OP_MOV, 1'b0, 32'd0, 32'd0, LSL, 8'd0, 1'b0, 5'd0);
    idle();
    tick(); tick();
    reset = 1'b1;
    chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
    chk_eq("rst_flags", 64'(flags), 64'd0);
    tick();
    chk_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Signed overflow on ADDS
    drive(OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1, LSL, 8'd0, 1'b0, 5'd1);
    tick(); idle(); tick();
    chk_eq("t1_vld", 64'(out_valid), 64'd1);
    chk_eq("t1_res", 64'(result), 64'h8000_0000);
    chk_eq("t1_tag", 64'(out_tag), 64'd1);
    tick();
    chk_eq("t1_flags", 64'(flags), 64'b1001);

    // ADDS carry forwarded into the following RRX
    drive(OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h1, LSL, 8'd0, 1'b0, 5'd2);
    tick();
    drive(OP_MOV, 1'b1, 32'h0, 32'h2, ROR, 8'd0, 1'b0, 5'd3);
    tick(); idle();
    chk_eq("t2a_res", 64'(result), 64'h0);
    chk_eq("t2a_tag", 64'(out_tag), 64'd2);
    tick();
    chk_eq("t2a_flags", 64'(flags), 64'b0110);
    chk_eq("t2b_res", 64'(result), 64'h8000_0001);
    chk_eq("t2b_tag", 64'(out_tag), 64'd3);
    tick();
    chk_eq("t2b_flags", 64'(flags), 64'b1000);

    // Register / boundary shift amounts, b = 0x80000001
    run_one("lsl32", OP_MOV, 32'h0, 32'h8000_0001, LSL, 8'd32, 1'b1, 32'h0,         1'b1, 4'b0110);
    run_one("lsr33", OP_MOV, 32'h0, 32'h8000_0001, LSR, 8'd33, 1'b1, 32'h0,         1'b1, 4'b0100);
    run_one("amt0c0", OP_MOV, 32'h0, 32'h8000_0001, LSR, 8'd0, 1'b1, 32'h8000_0001, 1'b1, 4'b1000);
    run_one("asr40", OP_MOV, 32'h0, 32'h8000_0001, ASR, 8'd40, 1'b1, 32'hFFFF_FFFF, 1'b1, 4'b1010);
    run_one("amt0c1", OP_MOV, 32'h0, 32'h8000_0001, LSL, 8'd0, 1'b1, 32'h8000_0001, 1'b1, 4'b1010);
    run_one("lsr33b", OP_MOV, 32'h0, 32'h8000_0001, LSR, 8'd33, 1'b1, 32'h0,        1'b1, 4'b0100);
    run_one("ror64", OP_MOV, 32'h0, 32'h8000_0001, ROR, 8'd64, 1'b1, 32'h8000_0001, 1'b1, 4'b1010);
    run_one("lsri0", OP_MOV, 32'h0, 32'h8000_0001, LSR, 8'd0, 1'b0, 32'h0,          1'b1, 4'b0110);

    // Backpressure: four ops, three stalled cycles
    q_op  = '{OP_ADD, OP_ADD, OP_SUB, OP_ORR};
    q_sf  = '{1'b1, 1'b0, 1'b1, 1'b0};
    q_a   = '{32'd1, 32'd10, 32'd5, 32'h0000_00F0};
    q_b   = '{32'd1, 32'd20, 32'd5, 32'h0000_000F};
    q_res = '{32'd2, 32'd30, 32'd0, 32'h0000_00FF};
    q_fl  = '{4'b0000, 4'b0000, 4'b0110, 4'b0110};
    begin
      int issued = 0;
      int retired = 0;
      for (int cyc = 0; cyc < 40 && retired < 4; cyc++) begin
        logic ret, acc;
        out_ready = (cyc >= 5);
        if (issued < 4) drive(q_op[issued], q_sf[issued], q_a[issued], q_b[issued], LSL, 8'd0, 1'b0, 5'(issued + 4));
        else idle();
        #1;
        if (cyc == 2) begin
          chk_eq("t4_in_ready_drop", 64'(in_ready), 64'd0);
          chk_eq("t4_accepted", 64'(issued), 64'd2);
        end
        ret = out_valid && out_ready;
        acc = in_valid && in_ready;
        if (out_valid) begin
          chk_eq("t4_res", 64'(result), 64'(q_res[retired]));
          chk_eq("t4_tag", 64'(out_tag), 64'(retired + 4));
          if (!out_ready) chk_eq("t4_stall_flags", 64'(flags), 64'b0110);
        end
        tick();
        if (acc) issued++;
        if (ret) begin
          chk_eq("t4_flags", 64'(flags), 64'(q_fl[retired]));
          retired++;
        end
      end
      chk_eq("t4_retired", 64'(retired), 64'd4);
    end
    idle();
    out_ready = 1'b1;

    // Subtract / compare flags
    run_one("subs", OP_SUB, 32'd3, 32'd5, LSL, 8'd0, 1'b0, 32'hFFFF_FFFE, 1'b1, 4'b1000);
    run_one("cmp",  OP_CMP, 32'd5, 32'd5, LSL, 8'd0, 1'b0, 32'h0,         1'b0, 4'b0110);

    // Flush with flag-setting ops in both stages
    drive(OP_SUB, 1'b1, 32'd3, 32'd5, LSL, 8'd0, 1'b0, 5'd10);
    tick();
    drive(OP_MOV, 1'b1, 32'd0, 32'd0, LSL, 8'd0, 1'b0, 5'd11);
    tick();
    idle();
    flush = 1'b1;
    #1;
    chk_eq("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk_eq("flush_vld", 64'(out_valid), 64'd0);
    chk_eq("flush_flags", 64'(flags), 64'b0110);
    tick();
    chk_eq("flush_vld2", 64'(out_valid), 64'd0);

    // Reset mid-stream
    drive(OP_SUB, 1'b1, 32'd3, 32'd5, LSL, 8'd0, 1'b0, 5'd12);
    tick();
    drive(OP_MOV, 1'b1, 32'd0, 32'd0, LSL, 8'd0, 1'b0, 5'd13);
    tick();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_eq("mrst_vld", 64'(out_valid), 64'd0);
    chk_eq("mrst_flags", 64'(flags), 64'd0);
    tick();
    chk_eq("mrst_in_ready", 64'(in_ready), 64'd1);
    chk_eq("mrst_vld2", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
